// File: rtl/fp_add_seq.sv
// Multi-cycle parametrised floating-point adder/subtractor: RNE rounding, {NV,OF,UF,NX} flags.
// Define DENORM_EN for gradual underflow; otherwise denormal inputs/outputs flush to signed zero.
module fp_add_seq #(
    parameter int EXPBITS  = 8,
    parameter int FRACBITS = 23
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXPBITS+FRACBITS:0] a,
    input  logic [EXPBITS+FRACBITS:0] b,
    input  logic                      sub,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXPBITS+FRACBITS:0] result,
    output logic [3:0]                flags
);

    localparam int W   = 1 + EXPBITS + FRACBITS;
    localparam int MW  = FRACBITS + 4;
    localparam int LZW = $clog2(FRACBITS + 5);
    localparam int EW  = ((EXPBITS > LZW) ? EXPBITS : LZW) + 2;
    localparam logic signed [EW-1:0] ONE  = EW'(1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXPBITS) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXPBITS{1'b1}}, 1'b1, {(FRACBITS-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

    state_t state, state_nx;

    logic [1:0] rst_sync;
    logic       rst_i;

    logic [W-1:0]          a_q, b_q, res_q;
    logic [3:0]            flags_q;
    logic                  sign_q, eff_sub_q, special_q, zero_q, tiny_q;
    logic signed [EW-1:0]  exp_q;
    logic [MW-1:0]         mx_q, my_q, m_q;
    logic [MW:0]           sum_q;

    logic                  sa, sb, a_den, b_den, a_nan, b_nan, a_inf, b_inf, a_snan, b_snan;
    logic [EXPBITS-1:0]    ea, eb;
    logic [FRACBITS-1:0]   fa, fb;
    logic signed [EW-1:0]  ea_e, eb_e, ex, ey;
    logic [MW-1:0]         ma, mb, mx, my, mask, my_al;
    logic [EW-1:0]         diff_u;
    logic                  a_ge, sp_hit, sp_nv;
    logic [W-1:0]          sp_res;

    logic [MW:0]           sum_n;
    logic signed [EW-1:0]  lz, sh, exp_n, exp_r;
    logic [MW-1:0]         m_n;
    logic                  tiny_n, up, nx, uf, hid;
    logic [FRACBITS+1:0]   rm;
    logic [FRACBITS-1:0]   frac_r;
    logic [W-1:0]          rnd_res;
    logic [3:0]            rnd_flags;

    function automatic logic signed [EW-1:0] lzc(input logic [MW-1:0] v);
        logic signed [EW-1:0] n;
        n = EW'(MW);
        for (int unsigned i = 0; i < MW; i++)
            if (v[i]) n = EW'(MW - 1 - i);
        return n;
    endfunction

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i = rst_sync[1];

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = ALIGN;
            end
            ALIGN:   state_nx = ADD;
            ADD:     state_nx = NORM;
            NORM:    state_nx = ROUND;
            ROUND:   state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign sa     = a_q[W-1];
    assign sb     = b_q[W-1];
    assign ea     = a_q[W-2:FRACBITS];
    assign eb     = b_q[W-2:FRACBITS];
    assign fa     = a_q[FRACBITS-1:0];
    assign fb     = b_q[FRACBITS-1:0];
    assign a_den  = ~|ea;
    assign b_den  = ~|eb;
    assign a_nan  = (&ea) & (|fa);
    assign b_nan  = (&eb) & (|fb);
    assign a_inf  = (&ea) & ~(|fa);
    assign b_inf  = (&eb) & ~(|fb);
    assign a_snan = a_nan & ~fa[FRACBITS-1];
    assign b_snan = b_nan & ~fb[FRACBITS-1];
    assign ea_e   = a_den ? ONE : EW'(ea);
    assign eb_e   = b_den ? ONE : EW'(eb);
`ifdef DENORM_EN
    assign ma = {~a_den, fa, 3'b000};
    assign mb = {~b_den, fb, 3'b000};
`else
    assign ma = a_den ? '0 : {1'b1, fa, 3'b000};
    assign mb = b_den ? '0 : {1'b1, fb, 3'b000};
`endif

    always_comb begin
        a_ge   = (ea_e > eb_e) || ((ea_e == eb_e) && (ma >= mb));
        ex     = a_ge ? ea_e : eb_e;
        ey     = a_ge ? eb_e : ea_e;
        mx     = a_ge ? ma : mb;
        my     = a_ge ? mb : ma;
        diff_u = ex - ey;
        mask   = ~({MW{1'b1}} << diff_u);
        if (diff_u >= EW'(FRACBITS + 3))
            my_al = {{(MW-1){1'b0}}, |my};
        else
            my_al = (my >> diff_u) | {{(MW-1){1'b0}}, |(my & mask)};
        sp_hit = 1'b1;
        sp_nv  = 1'b0;
        sp_res = QNAN;
        if (a_nan || b_nan)               sp_nv  = a_snan | b_snan;
        else if (a_inf && b_inf && sa != sb) sp_nv = 1'b1;
        else if (a_inf)                   sp_res = a_q;
        else if (b_inf)                   sp_res = b_q;
        else                              sp_hit = 1'b0;
    end

    // Operands are ordered by magnitude, so the subtraction never goes negative.
    assign sum_n = eff_sub_q ? ({1'b0, mx_q} - {1'b0, my_q}) : ({1'b0, mx_q} + {1'b0, my_q});

    always_comb begin
        lz     = lzc(sum_q[MW-1:0]);
        sh     = lz;
        tiny_n = 1'b0;
        if (sum_q[MW]) begin
            m_n   = {sum_q[MW:2], |sum_q[1:0]};
            exp_n = exp_q + ONE;
        end else begin
`ifdef DENORM_EN
            if (lz >= exp_q) sh = exp_q - ONE;
`else
            tiny_n = (exp_q <= lz);
`endif
            m_n   = sum_q[MW-1:0] << sh;
            exp_n = exp_q - sh;
        end
    end

    always_comb begin
        up     = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
        nx     = |m_q[2:0];
        rm     = {1'b0, m_q[MW-1:3]} + {{(FRACBITS+1){1'b0}}, up};
        exp_r  = rm[FRACBITS+1] ? exp_q + ONE : exp_q;
        frac_r = rm[FRACBITS+1] ? rm[FRACBITS:1] : rm[FRACBITS-1:0];
        hid    = rm[FRACBITS+1] | rm[FRACBITS];
`ifdef DENORM_EN
        uf = nx & ~m_q[MW-1];
`else
        uf = 1'b0;
`endif
        rnd_res   = {sign_q, (hid ? exp_r[EXPBITS-1:0] : {EXPBITS{1'b0}}), frac_r};
        rnd_flags = {2'b00, uf, nx};
        if (zero_q) begin
            rnd_res   = {sign_q, {(W-1){1'b0}}};
            rnd_flags = 4'b0000;
        end else if (tiny_q) begin
            rnd_res   = {sign_q, {(W-1){1'b0}}};
            rnd_flags = 4'b0011;
        end else if (exp_r >= EMAX) begin
            rnd_res   = {sign_q, {EXPBITS{1'b1}}, {FRACBITS{1'b0}}};
            rnd_flags = 4'b0101;
        end
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            flags_q   <= '0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            special_q <= 1'b0;
            zero_q    <= 1'b0;
            tiny_q    <= 1'b0;
            exp_q     <= '0;
            mx_q      <= '0;
            my_q      <= '0;
            m_q       <= '0;
            sum_q     <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q <= a;
                    b_q <= b ^ {sub, {(W-1){1'b0}}};
                end
                ALIGN: begin
                    sign_q    <= a_ge ? sa : sb;
                    eff_sub_q <= sa ^ sb;
                    exp_q     <= ex;
                    mx_q      <= mx;
                    my_q      <= my_al;
                    special_q <= sp_hit;
                    if (sp_hit) begin
                        res_q   <= sp_res;
                        flags_q <= {sp_nv, 3'b000};
                    end
                end
                ADD: begin
                    sum_q  <= sum_n;
                    zero_q <= (sum_n == '0);
                    if (sum_n == '0 && eff_sub_q) sign_q <= 1'b0;
                end
                NORM: begin
                    m_q    <= m_n;
                    exp_q  <= exp_n;
                    tiny_q <= tiny_n;
                end
                ROUND: if (!special_q) begin
                    res_q   <= rnd_res;
                    flags_q <= rnd_flags;
                end
                default: ;
            endcase
        end
    end

    assign result = res_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed-vector bench for fp_add_seq: binary32 and binary16 instances plus handshake/reset sequences.
module tb_fp_add_seq;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;

`ifdef DENORM_EN
    localparam logic [31:0] TINY_ADD    = 32'h00000002;
    localparam logic [31:0] TINY_SUB    = 32'h00000001;
    localparam logic [3:0]  TINY_SUB_FL = 4'h0;
`else
    localparam logic [31:0] TINY_ADD    = 32'h00000000;
    localparam logic [31:0] TINY_SUB    = 32'h00000000;
    localparam logic [3:0]  TINY_SUB_FL = 4'h3;
`endif

    logic        clk;
    logic        rst_n;
    logic        iv32, ir32, sub32, ov32, or32;
    logic [31:0] a32, b32, res32;
    logic [3:0]  fl32;
    logic        iv16, ir16, sub16, ov16, or16;
    logic [15:0] a16, b16, res16;
    logic [3:0]  fl16;

    int pass_cnt = 0;
    int total_cnt = 0;

    vec_t v32 [18];
    vec_t v16 [7];

    fp_add_seq #(.EXPBITS(8), .FRACBITS(23)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .sub(sub32), .out_valid(ov32), .out_ready(or32), .result(res32), .flags(fl32)
    );

    fp_add_seq #(.EXPBITS(5), .FRACBITS(10)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .sub(sub16), .out_valid(ov16), .out_ready(or16), .result(res16), .flags(fl16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic op32(input logic [31:0] ai, input logic [31:0] bi, input logic si,
                        output logic [31:0] r, output logic [3:0] f, output int lat);
        int n = 0;
        while (!ir32 && n < 50) begin @(posedge clk); #1; n++; end
        a32 = ai; b32 = bi; sub32 = si; iv32 = 1'b1; or32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        lat = 1;
        while (!ov32 && lat < 50) begin @(posedge clk); #1; lat++; end
        r = res32;
        f = fl32;
        @(posedge clk); #1;
    endtask

    task automatic op16(input logic [15:0] ai, input logic [15:0] bi, input logic si,
                        output logic [15:0] r, output logic [3:0] f, output int lat);
        int n = 0;
        while (!ir16 && n < 50) begin @(posedge clk); #1; n++; end
        a16 = ai; b16 = bi; sub16 = si; iv16 = 1'b1; or16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        lat = 1;
        while (!ov16 && lat < 50) begin @(posedge clk); #1; lat++; end
        r = res16;
        f = fl16;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] r32;
        logic [15:0] r16;
        logic [3:0]  f;
        int          lat, n, stable, t0, t1, spurious;

        v32[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0};
        v32[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0};
        v32[2]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'h8};
        v32[3]  = '{32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, 4'h8};
        v32[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5};
        v32[5]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1};
        v32[6]  = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'h1};
        v32[7]  = '{32'h00000001, 32'h00000001, 1'b0, TINY_ADD,      4'h0};
        v32[8]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0};
        v32[9]  = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'h0};
        v32[10] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'h0};
        v32[11] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'h0};
        v32[12] = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0};
        v32[13] = '{32'h40000000, 32'h40400000, 1'b0, 32'h40A00000, 4'h0};
        v32[14] = '{32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000, 4'h0};
        v32[15] = '{32'h00800001, 32'h00800000, 1'b1, TINY_SUB,      TINY_SUB_FL};
        v32[16] = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 4'h0};
        v32[17] = '{32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 4'h0};

        v16[0] = '{32'h3C00, 32'h3C00, 1'b0, 32'h4000, 4'h0};
        v16[1] = '{32'h3C00, 32'h3C00, 1'b1, 32'h0000, 4'h0};
        v16[2] = '{32'h7C00, 32'hFC00, 1'b0, 32'h7E00, 4'h8};
        v16[3] = '{32'h7C01, 32'h0000, 1'b0, 32'h7E00, 4'h8};
        v16[4] = '{32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 4'h5};
        v16[5] = '{32'h3C00, 32'h1000, 1'b0, 32'h3C00, 4'h1};
        v16[6] = '{32'h3C00, 32'h1001, 1'b0, 32'h3C01, 4'h1};

        rst_n = 1'b0;
        iv32 = 1'b0; sub32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0;
        iv16 = 1'b0; sub16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", {31'd0, ir32}, 32'd1);
        chk("reset out_valid", {31'd0, ov32}, 32'd0);
        chk("reset result", res32, 32'd0);
        chk("reset flags", {28'd0, fl32}, 32'd0);
        chk("reset result16", {16'd0, res16}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            op32(v32[i].a, v32[i].b, v32[i].sub, r32, f, lat);
            chk($sformatf("v32[%0d] result", i), r32, v32[i].res);
            chk($sformatf("v32[%0d] flags", i), {28'd0, f}, {28'd0, v32[i].fl});
            chk($sformatf("v32[%0d] latency", i), lat, 32'd5);
        end

        for (int i = 0; i < 7; i++) begin
            op16(v16[i].a[15:0], v16[i].b[15:0], v16[i].sub, r16, f, lat);
            chk($sformatf("v16[%0d] result", i), {16'd0, r16}, v16[i].res);
            chk($sformatf("v16[%0d] flags", i), {28'd0, f}, {28'd0, v16[i].fl});
            chk($sformatf("v16[%0d] latency", i), lat, 32'd5);
        end

        // Consumer stall: result must hold and new operands must be ignored.
        or32 = 1'b0; a32 = 32'h3F800000; b32 = 32'h3F800000; sub32 = 1'b0; iv32 = 1'b1;
        @(posedge clk); #1;
        a32 = 32'h40400000; b32 = 32'h40400000;
        n = 0;
        while (!ov32 && n < 50) begin @(posedge clk); #1; n++; end
        stable = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (ov32 && !ir32 && res32 == 32'h40000000 && fl32 == 4'h0) stable++;
        end
        chk("stall hold cycles", stable, 32'd10);
        iv32 = 1'b0; or32 = 1'b1;
        @(posedge clk); #1;
        chk("stall release out_valid", {31'd0, ov32}, 32'd0);
        chk("stall release in_ready", {31'd0, ir32}, 32'd1);

        // Back-to-back operands with out_ready high: one result every 6 cycles.
        a32 = 32'h3F800000; b32 = 32'h3F800000; sub32 = 1'b0; or32 = 1'b1; iv32 = 1'b1;
        t0 = 0; t1 = 0; n = 0;
        for (int c = 1; c <= 30 && n < 2; c++) begin
            @(posedge clk); #1;
            if (ov32) begin
                if (n == 0) t0 = c;
                else        t1 = c;
                n++;
            end
        end
        iv32 = 1'b0;
        chk("throughput spacing", t1 - t0, 32'd6);
        chk("throughput result", res32, 32'h40000000);
        @(posedge clk); #1;

        // Reset while the operation sits in ADD must discard it.
        a32 = 32'h3F800000; b32 = 32'h33800001; sub32 = 1'b0; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid-op reset out_valid", {31'd0, ov32}, 32'd0);
        chk("mid-op reset in_ready", {31'd0, ir32}, 32'd1);
        chk("mid-op reset result", res32, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        spurious = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (ov32) spurious++;
        end
        chk("no spurious result", spurious, 32'd0);
        chk("post-reset in_ready", {31'd0, ir32}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
